// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions.
// Holds the fetch FSM encoding, the NOP word used as the idle decode
// payload, the sequential PC step, and the packed queue entry layout.
package rv32i_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] PC_INC    = 32'd4;

  // Queue entry: the address a word was fetched from plus the word itself.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO sitting between instruction fetch and decode.
//   clk, rst_n  : clock, async active-low reset (empties the queue)
//   i_push/i_data : write an entry (ignored when full unless popping)
//   i_pop       : remove the head (ignored when empty)
//   i_flush     : drop everything; overrides push and pop
//   o_data      : head entry (don't-care when empty)
//   o_full/o_empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push, w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

  // A push into a full queue is legal when the head leaves the same cycle.
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

  assign o_data = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IDLE/FETCH control and a queue
// of fetched {pc, instr} pairs toward decode.
//   clk, rst_n                 : clock, async active-low reset
//   fetch_en                   : fetching permitted while high
//   imem_addr / imem_instr     : combinational ROM interface
//   redirect_valid/redirect_pc : branch/jump redirect, highest priority
//   out_valid/out_ready        : decode handshake
//   out_instr/out_pc           : head word and its address (NOP/RESET_PC
//                                while the queue is empty)
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RST_PC_A   = RESET_PC & ALIGN_MASK;

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_redir_pc;
  logic         w_push, w_pop, w_full, w_empty;
  fetch_entry_t w_wr_entry, w_head;

  // r_pc only ever holds aligned values, so it drives the ROM directly.
  assign imem_addr  = r_pc;
  assign w_redir_pc = redirect_pc & ALIGN_MASK;

  // Redirect suppresses both queue ports; the queue is flushed instead.
  assign w_pop  = out_valid & out_ready & ~redirect_valid;
  assign w_push = (r_state == FETCH) & ~redirect_valid & (~w_full | w_pop);

  assign w_wr_entry = '{pc: r_pc, instr: imem_instr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // A redirect keeps FETCH alive even if fetch_en drops the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (fetch_en) w_state_nxt = FETCH;
      FETCH:   if (!fetch_en && !redirect_valid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_pc <= RST_PC_A;
    else if (redirect_valid) r_pc <= w_redir_pc;
    else if (w_push)         r_pc <= r_pc + PC_INC;
  end

  fetch_queue #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_wr_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = ~w_empty;
  assign out_instr = w_empty ? NOP_INSTR : w_head.instr;
  assign out_pc    = w_empty ? RST_PC_A  : w_head.pc;

endmodule
